// File: rtl/adder_seq_ctrl_pkg.sv
// Purpose: shared types and helpers for the nibble-serial add/subtract sequencer.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width : nibble-counter width, clog2(n) with a floor of 1 bit
package adder_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder_4bit.sv
// Purpose: 4-bit ripple adder slice (purely combinational).
// Ports:
//   in_a, in_b : 4-bit addends
//   in_c       : carry-in
//   out_s      : 4-bit sum
//   out_c      : carry-out
module adder_4bit (
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_c,
  output logic [3:0] out_s,
  output logic       out_c
);

  logic [4:0] w_carry;

  // Explicit ripple chain, one full adder per bit
  always_comb begin
    w_carry[0] = in_c;
    for (int i = 0; i < 4; i++) begin
      out_s[i]       = in_a[i] ^ in_b[i] ^ w_carry[i];
      w_carry[i + 1] = (in_a[i] & in_b[i]) | (w_carry[i] & (in_a[i] ^ in_b[i]));
    end
  end

  assign out_c = w_carry[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Purpose: wide add/subtract done one nibble per clock through a single 4-bit
//   slice, LSB nibble first, with the carry registered between nibbles.
// Ports:
//   in_clk, in_rst      : clock (rising edge), synchronous active-high reset
//   in_valid/out_ready  : operand handshake (out_ready high only in IDLE)
//   in_a, in_b          : W-bit operands, W = 4*NIBBLES
//   in_c                : carry-in for add, ignored for subtract
//   in_sub              : 0 = A+B+in_c, 1 = A-B
//   out_valid/in_res_ready : result handshake
//   out_s, out_c, out_ovf  : result, carry-out of bit W-1, signed overflow
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_valid,
  output logic                   out_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_c,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   in_res_ready,
  output logic [4*NIBBLES-1:0]   out_s,
  output logic                   out_c,
  output logic                   out_ovf
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = cnt_width(NIBBLES);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic            r_carry;
  logic            r_ovf;
  logic [CW-1:0]   r_k;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_sum;
  logic            w_cout;
  logic            w_last;
  logic            w_accept;

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)     w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)       w_state_nxt = ST_DONE;
      ST_DONE: if (in_res_ready) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on in_valid
  always_comb begin
    out_ready = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: out_ready = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_k == CW'(NIBBLES - 1));

  // Nibble select for the current step
  assign w_a_nib = 4'(r_a >> {r_k, 2'b00});
  assign w_b_nib = 4'(r_b >> {r_k, 2'b00});

  adder_4bit u_slice (
    .in_a  (w_a_nib),
    .in_b  (w_b_nib),
    .in_c  (r_carry),
    .out_s (w_sum),
    .out_c (w_cout)
  );

  // Operand capture, per-nibble result write, carry chain and overflow
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with 1
      r_a     <= in_a;
      r_b     <= in_sub ? ~in_b : in_b;
      r_carry <= in_sub ? 1'b1 : in_c;
      r_k     <= '0;
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < int'(NIBBLES); i++) begin
        if (CW'(i) == r_k) r_res[4*i +: 4] <= w_sum;
      end
      r_carry <= w_cout;
      r_k     <= r_k + CW'(1);
      // Same-sign operands producing a different-sign result
      if (w_last) r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_sum[3] != r_a[W-1]);
    end
  end

  assign out_s   = r_res;
  assign out_c   = r_carry;
  assign out_ovf = r_ovf;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with NIBBLES=4 (16-bit operands).
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_c;
  logic        in_sub;
  logic        out_valid;
  logic        in_res_ready;
  logic [15:0] out_s;
  logic        out_c;
  logic        out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  adder_seq_ctrl #(.NIBBLES(4)) dut (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .in_res_ready (in_res_ready),
    .out_s        (out_s),
    .out_c        (out_c),
    .out_ovf      (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the result
  // becomes visible. Operand inputs are scrambled after acceptance.
  task automatic accept_and_wait(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic sub, input string tag);
    in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_c = ~c; in_sub = ~sub;
    chk({tag, "_ready_run"}, 32'(out_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic sub, input logic [15:0] es, input logic ec,
                        input logic eo, input string tag);
    accept_and_wait(a, b, c, sub, tag);
    chk({tag, "_s"},   32'(out_s),   32'(es));
    chk({tag, "_c"},   32'(out_c),   32'(ec));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    in_res_ready = 1'b1;
    @(negedge clk);
    in_res_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(out_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0;
    in_sub = 1'b0; in_res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_s",     32'(out_s),     32'd0);
    chk("rst_c",     32'(out_c),     32'd0);
    chk("rst_ovf",   32'(out_ovf),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0, "add_cin");
    // in_c=1 must be ignored for subtract
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");

    // Backpressure: result held for 10 cycles while a new op is offered
    accept_and_wait(16'h1111, 16'h2222, 1'b0, 1'b0, "bp");
    in_a = 16'h0002; in_b = 16'h0003; in_c = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(out_ready), 32'd0);
      chk("bp_hold_s",     32'(out_s),     32'h3333);
      @(negedge clk);
    end
    in_res_ready = 1'b1;
    @(negedge clk);
    in_res_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(out_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_ready", 32'(out_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("bp_next_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_s",     32'(out_s),     32'h0005);
    in_res_ready = 1'b1;
    @(negedge clk);
    in_res_ready = 1'b0;

    // Reset two cycles after acceptance discards the partial result
    in_a = 16'h5555; in_b = 16'h1111; in_c = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(out_ready), 32'd1);
    chk("mid_rst_s",     32'(out_s),     32'd0);
    chk("mid_rst_c",     32'(out_c),     32'd0);
    chk("mid_rst_ovf",   32'(out_ovf),   32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
